// File: rtl/agex_muldiv_unit_pkg.sv
// Shared definitions for the AGEX iterative multiply/divide unit:
// funct3 operation codes, FSM state encoding, DE->AGEX field widths
// and small operand-signedness helpers.
package agex_md_pkg;

   // funct3 encodings of the M-extension operations
   localparam logic [2:0] MD_MUL    = 3'b000;
   localparam logic [2:0] MD_MULH   = 3'b001;
   localparam logic [2:0] MD_MULHSU = 3'b010;
   localparam logic [2:0] MD_MULHU  = 3'b011;
   localparam logic [2:0] MD_DIV    = 3'b100;
   localparam logic [2:0] MD_DIVU   = 3'b101;
   localparam logic [2:0] MD_REM    = 3'b110;
   localparam logic [2:0] MD_REMU   = 3'b111;

   // DE->AGEX M-extension latch field widths
   localparam int MD_OP_W  = 3;
   localparam int MD_XLEN  = 32;
   localparam int MD_TAG_W = 5;

   typedef enum logic [1:0] {
      MD_IDLE = 2'd0,
      MD_CALC = 2'd1,
      MD_DONE = 2'd2
   } md_state_t;

   // rs1 is interpreted as signed for MUL, MULH, MULHSU, DIV and REM
   function automatic logic md_rs1_signed(input logic [2:0] op);
      return (op == MD_MUL) || (op == MD_MULH) || (op == MD_MULHSU) ||
             (op == MD_DIV) || (op == MD_REM);
   endfunction

   // rs2 is interpreted as signed for MUL, MULH, DIV and REM
   function automatic logic md_rs2_signed(input logic [2:0] op);
      return (op == MD_MUL) || (op == MD_MULH) ||
             (op == MD_DIV) || (op == MD_REM);
   endfunction

endpackage

// File: rtl/agex_muldiv_unit_if.sv
// DE->AGEX request / AGEX-latch result bundle for the multiply/divide unit.
// master = the stage driving operations in and taking results out;
// slave  = the multiply/divide unit itself.
interface agex_muldiv_unit_if
   import agex_md_pkg::*;
#(
   parameter int XLEN  = MD_XLEN,
   parameter int TAG_W = MD_TAG_W
);

   logic                 flush;
   logic                 in_valid;
   logic                 in_ready;
   logic [MD_OP_W-1:0]   in_op;
   logic [XLEN-1:0]      in_rs1;
   logic [XLEN-1:0]      in_rs2;
   logic [TAG_W-1:0]     in_tag;
   logic                 out_valid;
   logic                 out_ready;
   logic [XLEN-1:0]      out_result;
   logic [TAG_W-1:0]     out_tag;
   logic                 busy;

   modport master (
      output flush, in_valid, in_op, in_rs1, in_rs2, in_tag, out_ready,
      input  in_ready, out_valid, out_result, out_tag, busy
   );

   modport slave (
      input  flush, in_valid, in_op, in_rs1, in_rs2, in_tag, out_ready,
      output in_ready, out_valid, out_result, out_tag, busy
   );

endinterface

// File: rtl/agex_muldiv_unit_md_sign_fix.sv
// Conditional two's-complement negate of a double-width value followed by
// a low/high half select. Used both to take operand magnitudes on accept
// and to sign-correct and pick the final result on the fix-up edge.
module md_sign_fix #(
   parameter int W = 32
) (
   input  logic [2*W-1:0] value,
   input  logic           neg,
   input  logic           sel_hi,
   output logic [W-1:0]   result
);

   logic [2*W-1:0] fixed;

   assign fixed  = neg ? -value : value;
   assign result = sel_hi ? fixed[2*W-1:W] : fixed[W-1:0];

endmodule

// File: rtl/agex_muldiv_unit.sv
// Iterative RISC-V M-extension unit for the AGEX stage. One operation at a
// time, one multiplier/quotient bit per cycle, result and destination tag
// presented on a valid/ready port. Divide-by-zero and signed overflow are
// resolved at accept and skip the iteration entirely.
module agex_muldiv_unit
   import agex_md_pkg::*;
#(
   parameter int XLEN  = MD_XLEN,
   parameter int TAG_W = MD_TAG_W
) (
   input logic              clk,
   input logic              reset,
   agex_muldiv_unit_if.slave io
);

   localparam int CNT_W = $clog2(XLEN) + 1;

   md_state_t         state;
   md_state_t         state_next;
   logic              accept;

   logic [2:0]        op;
   logic              sign_q;
   logic              sign_r;
   logic [XLEN-1:0]   opnd;
   logic [2*XLEN-1:0] acc;
   logic [CNT_W-1:0]  cnt;
   logic [XLEN-1:0]   result_q;
   logic [TAG_W-1:0]  tag_q;

   logic              neg_a;
   logic              neg_b;
   logic [XLEN-1:0]   a_mag;
   logic [XLEN-1:0]   b_mag;
   logic              div_zero;
   logic              div_ovf;
   logic              special;
   logic [XLEN-1:0]   special_val;

   logic [XLEN:0]     mul_sum;
   logic [XLEN:0]     div_diff;
   logic [2*XLEN-1:0] acc_step;

   logic              op_div;
   logic              op_rem;
   logic [2*XLEN-1:0] post_value;
   logic              post_neg;
   logic              post_sel_hi;
   logic [XLEN-1:0]   post_result;

   assign io.in_ready   = (state == MD_IDLE);
   assign io.out_valid  = (state == MD_DONE);
   assign io.busy       = (state != MD_IDLE);
   assign io.out_result = result_q;
   assign io.out_tag    = tag_q;

   md_sign_fix #(.W(XLEN)) u_abs_a (
      .value  ({{XLEN{1'b0}}, io.in_rs1}),
      .neg    (neg_a),
      .sel_hi (1'b0),
      .result (a_mag)
   );

   md_sign_fix #(.W(XLEN)) u_abs_b (
      .value  ({{XLEN{1'b0}}, io.in_rs2}),
      .neg    (neg_b),
      .sel_hi (1'b0),
      .result (b_mag)
   );

   md_sign_fix #(.W(XLEN)) u_post (
      .value  (post_value),
      .neg    (post_neg),
      .sel_hi (post_sel_hi),
      .result (post_result)
   );

   // Decode the incoming operands: signs, and the results of divide-by-zero / overflow
   always_comb begin
      neg_a       = md_rs1_signed(io.in_op) && io.in_rs1[XLEN-1];
      neg_b       = md_rs2_signed(io.in_op) && io.in_rs2[XLEN-1];
      div_zero    = io.in_op[2] && (io.in_rs2 == '0);
      div_ovf     = ((io.in_op == MD_DIV) || (io.in_op == MD_REM)) &&
                    (io.in_rs1 == {1'b1, {(XLEN-1){1'b0}}}) &&
                    (io.in_rs2 == '1);
      special     = div_zero || div_ovf;
      special_val = '0;
      if (div_zero) begin
         special_val = io.in_op[1] ? io.in_rs1 : '1;
      end else if (div_ovf) begin
         special_val = io.in_op[1] ? '0 : io.in_rs1;
      end
   end

   // One iteration step: shift-add for multiply, restoring subtract for divide
   always_comb begin
      mul_sum  = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, opnd} : '0);
      div_diff = acc[2*XLEN-1:XLEN-1] - {1'b0, opnd};
      acc_step = {mul_sum, acc[XLEN-1:1]};
      if (op[2]) begin
         if (div_diff[XLEN]) begin
            acc_step = {acc[2*XLEN-2:0], 1'b0};
         end else begin
            acc_step = {div_diff[XLEN-1:0], acc[XLEN-2:0], 1'b1};
         end
      end
   end

   // Pick which accumulator part and which recorded sign feed the fix-up
   always_comb begin
      op_div      = op[2];
      op_rem      = op[2] && op[1];
      post_value  = acc;
      post_neg    = sign_q;
      post_sel_hi = (op != MD_MUL);
      if (op_div) begin
         post_value  = {{XLEN{1'b0}}, (op_rem ? acc[2*XLEN-1:XLEN] : acc[XLEN-1:0])};
         post_neg    = op_rem ? sign_r : sign_q;
         post_sel_hi = 1'b0;
      end
   end

   // State register
   always_ff @(posedge clk) begin
      if (reset) begin
         state <= MD_IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Next-state logic; flush always returns to IDLE and blocks any accept
   always_comb begin
      state_next = state;
      accept     = 1'b0;
      case (state)
         MD_IDLE: begin
            if (io.in_valid && !io.flush) begin
               accept     = 1'b1;
               state_next = special ? MD_DONE : MD_CALC;
            end
         end
         MD_CALC: begin
            if (cnt == '0) begin
               state_next = MD_DONE;
            end
         end
         MD_DONE: begin
            if (io.out_ready) begin
               state_next = MD_IDLE;
            end
         end
         default: state_next = MD_IDLE;
      endcase
      if (io.flush) begin
         state_next = MD_IDLE;
      end
   end

   // Datapath: load on accept, iterate while the counter runs, fix up when it hits zero
   always_ff @(posedge clk) begin
      if (reset) begin
         op       <= MD_MUL;
         sign_q   <= 1'b0;
         sign_r   <= 1'b0;
         opnd     <= '0;
         acc      <= '0;
         cnt      <= '0;
         result_q <= '0;
         tag_q    <= '0;
      end else if (accept) begin
         op     <= io.in_op;
         tag_q  <= io.in_tag;
         sign_q <= neg_a ^ neg_b;
         sign_r <= neg_a;
         cnt    <= CNT_W'(XLEN);
         if (io.in_op[2]) begin
            opnd <= b_mag;
            acc  <= {{XLEN{1'b0}}, a_mag};
         end else begin
            opnd <= a_mag;
            acc  <= {{XLEN{1'b0}}, b_mag};
         end
         if (special) begin
            result_q <= special_val;
         end
      end else if ((state == MD_CALC) && !io.flush) begin
         if (cnt != '0) begin
            acc <= acc_step;
            cnt <= cnt - CNT_W'(1);
         end else begin
            result_q <= post_result;
         end
      end
   end

endmodule

// File: tb/tb_agex_muldiv_unit.sv
// Directed bench for agex_muldiv_unit: one 32-bit and one 64-bit instance,
// hand-computed results, latency, backpressure, flush and reset behaviour.
module tb_agex_muldiv_unit;
   import agex_md_pkg::*;

   logic clk = 1'b0;
   logic reset;

   int tests_run    = 0;
   int tests_failed = 0;

   agex_muldiv_unit_if #(.XLEN(32), .TAG_W(5)) bus32 ();
   agex_muldiv_unit_if #(.XLEN(64), .TAG_W(5)) bus64 ();

   agex_muldiv_unit #(.XLEN(32), .TAG_W(5)) dut32 (
      .clk   (clk),
      .reset (reset),
      .io    (bus32)
   );

   agex_muldiv_unit #(.XLEN(64), .TAG_W(5)) dut64 (
      .clk   (clk),
      .reset (reset),
      .io    (bus64)
   );

   // Free-running clock, 10 time units per cycle
   always #5 clk = ~clk;

   // Hang guard in case the DUT never returns a result
   initial begin
      #500000;
      $display("[TB] FAIL watchdog: simulation did not finish, tests run %0d", tests_run);
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic checkOutput(input string name, input logic [63:0] actual,
                              input logic [63:0] expected);
      tests_run++;
      if (actual !== expected) begin
         tests_failed++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Offer one operation to the 32-bit unit; returns 1ns after the accept edge
   task automatic applyStimulus(input logic [2:0] op, input logic [31:0] a,
                                input logic [31:0] b, input logic [4:0] tag);
      int guard = 0;
      while (!bus32.in_ready && guard < 100) begin
         tick();
         guard++;
      end
      checkOutput("issue_in_ready", bus32.in_ready, 1);
      bus32.in_valid = 1'b1;
      bus32.in_op    = op;
      bus32.in_rs1   = a;
      bus32.in_rs2   = b;
      bus32.in_tag   = tag;
      tick();
      bus32.in_valid = 1'b0;
   endtask

   // Count edges after the accept edge until out_valid is seen (bounded)
   task automatic waitResult32(output int lat, output logic busy_all);
      lat      = 0;
      busy_all = bus32.busy;
      while (!bus32.out_valid && lat < 200) begin
         tick();
         lat++;
         if (!bus32.busy) busy_all = 1'b0;
      end
   endtask

   task automatic runOp32(input string name, input logic [2:0] op,
                          input logic [31:0] a, input logic [31:0] b,
                          input logic [4:0] tag, input logic [31:0] expv,
                          input int exp_lat);
      int   lat;
      logic busy_all;
      applyStimulus(op, a, b, tag);
      waitResult32(lat, busy_all);
      checkOutput({name, "_result"}, bus32.out_result, expv);
      checkOutput({name, "_tag"}, bus32.out_tag, tag);
      checkOutput({name, "_latency"}, lat, exp_lat);
      checkOutput({name, "_busy"}, busy_all, 1);
      bus32.out_ready = 1'b1;
      tick();
      bus32.out_ready = 1'b0;
      checkOutput({name, "_in_ready_after"}, bus32.in_ready, 1);
      checkOutput({name, "_out_valid_after"}, bus32.out_valid, 0);
   endtask

   task automatic runOp64(input string name, input logic [2:0] op,
                          input logic [63:0] a, input logic [63:0] b,
                          input logic [4:0] tag, input logic [63:0] expv,
                          input int exp_lat);
      int guard = 0;
      int lat   = 0;
      while (!bus64.in_ready && guard < 100) begin
         tick();
         guard++;
      end
      checkOutput({name, "_issue_in_ready"}, bus64.in_ready, 1);
      bus64.in_valid = 1'b1;
      bus64.in_op    = op;
      bus64.in_rs1   = a;
      bus64.in_rs2   = b;
      bus64.in_tag   = tag;
      tick();
      bus64.in_valid = 1'b0;
      while (!bus64.out_valid && lat < 300) begin
         tick();
         lat++;
      end
      checkOutput({name, "_result"}, bus64.out_result, expv);
      checkOutput({name, "_tag"}, bus64.out_tag, tag);
      checkOutput({name, "_latency"}, lat, exp_lat);
      bus64.out_ready = 1'b1;
      tick();
      bus64.out_ready = 1'b0;
      checkOutput({name, "_in_ready_after"}, bus64.in_ready, 1);
   endtask

   initial begin
      int   seen;
      int   lat;
      logic busy_all;

      reset = 1'b1;
      bus32.flush = 1'b0; bus32.in_valid = 1'b0; bus32.in_op = MD_MUL;
      bus32.in_rs1 = '0;  bus32.in_rs2 = '0;     bus32.in_tag = '0;
      bus32.out_ready = 1'b0;
      bus64.flush = 1'b0; bus64.in_valid = 1'b0; bus64.in_op = MD_MUL;
      bus64.in_rs1 = '0;  bus64.in_rs2 = '0;     bus64.in_tag = '0;
      bus64.out_ready = 1'b0;

      tick();
      tick();
      reset = 1'b0;
      checkOutput("reset_in_ready", bus32.in_ready, 1);
      checkOutput("reset_out_valid", bus32.out_valid, 0);
      checkOutput("reset_busy", bus32.busy, 0);
      checkOutput("reset_out_result", bus32.out_result, 0);
      checkOutput("reset_out_tag", bus32.out_tag, 0);

      // Multiplies
      runOp32("mul_7_m3", MD_MUL, 32'd7, 32'hFFFFFFFD, 5'd1, 32'hFFFFFFEB, 33);
      runOp32("mulh_min_min", MD_MULH, 32'h80000000, 32'h80000000, 5'd2, 32'h40000000, 33);
      runOp32("mulhu_max", MD_MULHU, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd3, 32'hFFFFFFFE, 33);
      runOp32("mulhsu_m1", MD_MULHSU, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd4, 32'hFFFFFFFF, 33);

      // Divides
      runOp32("div_m20_3", MD_DIV, 32'hFFFFFFEC, 32'd3, 5'd5, 32'hFFFFFFFA, 33);
      runOp32("rem_m20_3", MD_REM, 32'hFFFFFFEC, 32'd3, 5'd6, 32'hFFFFFFFE, 33);
      runOp32("divu_100_7", MD_DIVU, 32'd100, 32'd7, 5'd7, 32'd14, 33);
      runOp32("remu_100_7", MD_REMU, 32'd100, 32'd7, 5'd8, 32'd2, 33);

      // Divide corner cases resolved at accept
      runOp32("div_by0", MD_DIV, 32'h12345678, 32'd0, 5'd9, 32'hFFFFFFFF, 0);
      runOp32("rem_5_by0", MD_REM, 32'd5, 32'd0, 5'd10, 32'd5, 0);
      runOp32("div_ovf", MD_DIV, 32'h80000000, 32'hFFFFFFFF, 5'd11, 32'h80000000, 0);
      runOp32("rem_ovf", MD_REM, 32'h80000000, 32'hFFFFFFFF, 5'd12, 32'd0, 0);
      runOp32("divu_m1_not_ovf", MD_DIVU, 32'h80000000, 32'hFFFFFFFF, 5'd13, 32'd0, 33);

      // Backpressure: result held, new offers refused
      applyStimulus(MD_MUL, 32'd7, 32'hFFFFFFFD, 5'd21);
      waitResult32(lat, busy_all);
      checkOutput("bp_latency", lat, 33);
      bus32.in_valid = 1'b1;
      bus32.in_op    = MD_DIVU;
      bus32.in_rs1   = 32'd1;
      bus32.in_rs2   = 32'd1;
      bus32.in_tag   = 5'd30;
      for (int i = 0; i < 10; i++) begin
         tick();
         checkOutput("bp_out_valid", bus32.out_valid, 1);
         checkOutput("bp_result", bus32.out_result, 32'hFFFFFFEB);
         checkOutput("bp_tag", bus32.out_tag, 21);
         checkOutput("bp_in_ready", bus32.in_ready, 0);
      end
      bus32.in_valid  = 1'b0;
      bus32.out_ready = 1'b1;
      tick();
      bus32.out_ready = 1'b0;
      checkOutput("bp_in_ready_after", bus32.in_ready, 1);
      checkOutput("bp_out_valid_after", bus32.out_valid, 0);
      tick();
      checkOutput("bp_not_accepted", bus32.busy, 0);

      // Flush five cycles into CALC
      applyStimulus(MD_MUL, 32'd6, 32'd7, 5'd14);
      for (int i = 0; i < 4; i++) tick();
      bus32.flush = 1'b1;
      tick();
      bus32.flush = 1'b0;
      checkOutput("flush_calc_busy", bus32.busy, 0);
      checkOutput("flush_calc_in_ready", bus32.in_ready, 1);
      seen = 0;
      for (int i = 0; i < 40; i++) begin
         if (bus32.out_valid) seen++;
         tick();
      end
      checkOutput("flush_calc_no_valid", seen, 0);
      runOp32("mul_after_flush", MD_MUL, 32'd6, 32'd7, 5'd15, 32'd42, 33);

      // Flush coincident with an offer
      bus32.in_valid = 1'b1;
      bus32.in_op    = MD_MUL;
      bus32.in_rs1   = 32'd2;
      bus32.in_rs2   = 32'd3;
      bus32.in_tag   = 5'd16;
      bus32.flush    = 1'b1;
      tick();
      bus32.in_valid = 1'b0;
      bus32.flush    = 1'b0;
      checkOutput("flush_accept_busy", bus32.busy, 0);
      tick();
      checkOutput("flush_accept_out_valid", bus32.out_valid, 0);

      // Flush beats a same-cycle out_ready in DONE
      applyStimulus(MD_DIVU, 32'd100, 32'd7, 5'd17);
      waitResult32(lat, busy_all);
      bus32.flush     = 1'b1;
      bus32.out_ready = 1'b1;
      tick();
      bus32.flush     = 1'b0;
      bus32.out_ready = 1'b0;
      checkOutput("flush_done_out_valid", bus32.out_valid, 0);
      checkOutput("flush_done_busy", bus32.busy, 0);

      // Reset mid-CALC
      applyStimulus(MD_MUL, 32'd6, 32'd7, 5'd18);
      for (int i = 0; i < 10; i++) tick();
      reset = 1'b1;
      tick();
      reset = 1'b0;
      checkOutput("rst_calc_out_valid", bus32.out_valid, 0);
      checkOutput("rst_calc_out_result", bus32.out_result, 0);
      checkOutput("rst_calc_out_tag", bus32.out_tag, 0);
      checkOutput("rst_calc_busy", bus32.busy, 0);
      checkOutput("rst_calc_in_ready", bus32.in_ready, 1);

      // 64-bit instance
      runOp64("x64_mul_7_m3", MD_MUL, 64'd7, 64'hFFFFFFFFFFFFFFFD, 5'd1,
              64'hFFFFFFFFFFFFFFEB, 65);
      runOp64("x64_div_m20_3", MD_DIV, 64'hFFFFFFFFFFFFFFEC, 64'd3, 5'd2,
              64'hFFFFFFFFFFFFFFFA, 65);
      runOp64("x64_rem_m20_3", MD_REM, 64'hFFFFFFFFFFFFFFEC, 64'd3, 5'd3,
              64'hFFFFFFFFFFFFFFFE, 65);
      runOp64("x64_divu_100_7", MD_DIVU, 64'd100, 64'd7, 5'd4, 64'd14, 65);
      runOp64("x64_remu_100_7", MD_REMU, 64'd100, 64'd7, 5'd5, 64'd2, 65);
      runOp64("x64_div_by0", MD_DIV, 64'd9, 64'd0, 5'd6, 64'hFFFFFFFFFFFFFFFF, 0);
      runOp64("x64_div_ovf", MD_DIV, 64'h8000000000000000, 64'hFFFFFFFFFFFFFFFF, 5'd7,
              64'h8000000000000000, 0);

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
